// File: rtl/memory_if.sv
// rtl/memory_if.sv - word-addressed memory bus with keyboard strobe inputs
interface memory_if;
    logic [31:0] addr;
    logic        MemWrite;
    logic [31:0] WD;
    logic        sample;
    logic [7:0]  key_reg;
    logic [31:0] RD;

    modport master (
        output addr, MemWrite, WD, sample, key_reg,
        input  RD
    );

    modport slave (
        input  addr, MemWrite, WD, sample, key_reg,
        output RD
    );
endinterface

// File: rtl/memory.sv
// rtl/memory.sv - 16K-word RAM with a memory-mapped keyboard register at KBD_ADDR
module memory #(
    parameter logic [13:0] KBD_ADDR = 14'h3FFF
) (
    input  logic     clk,
    input  logic     rst_n,
    memory_if.slave  bus
);
    logic [31:0] mem [0:16383];
    logic [13:0] idx;
    logic        is_kbd;
    logic        sample_q;
    logic [7:0]  kbd_data;
    logic        kbd_valid;
    logic        sample_rise;
    logic        unused_addr_bits;

    assign idx              = bus.addr[13:0];
    assign is_kbd           = (idx == KBD_ADDR);
    assign sample_rise      = bus.sample & ~sample_q;
    assign unused_addr_bits = ^bus.addr[31:14];

    // RAM has no reset; a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (rst_n && bus.MemWrite && !is_kbd) begin
            mem[idx] <= bus.WD;
        end
    end

    // Capture beats a same-cycle software clear of kbd_valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sample_q  <= 1'b0;
            kbd_data  <= 8'h00;
            kbd_valid <= 1'b0;
        end else begin
            sample_q <= bus.sample;
            if (sample_rise) begin
                kbd_data  <= bus.key_reg;
                kbd_valid <= 1'b1;
            end else if (bus.MemWrite && is_kbd && !bus.WD[8]) begin
                kbd_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.RD = mem[idx];
        if (is_kbd) begin
            bus.RD = {23'b0, kbd_valid, kbd_data};
        end
    end
endmodule

// File: tb/tb_memory.sv
// tb/tb_memory.sv - directed and randomized checks of memory against a behavioural model
module tb_memory;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    memory_if bus();

    memory #(.KBD_ADDR(14'h3FFF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    localparam int KBD = 16383;

    // Reference model: sparse word store plus keyboard state.
    logic [31:0] ref_mem [int];
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_prev_sample;

    task automatic model_edge();
        int i;
        logic rise;
        i = int'(bus.addr % 32'd16384);
        if (!rst_n) begin
            m_data = 8'h00; m_valid = 1'b0; m_prev_sample = 1'b0;
        end else begin
            if (bus.MemWrite && i != KBD) ref_mem[i] = bus.WD;
            rise = bus.sample && !m_prev_sample;
            if (rise) begin
                m_data = bus.key_reg; m_valid = 1'b1;
            end else if (bus.MemWrite && i == KBD && !bus.WD[8]) begin
                m_valid = 1'b0;
            end
            m_prev_sample = bus.sample;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] exp);
        checks++;
        assert (bus.RD === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, bus.RD, exp);
        end
    endtask

    task automatic check_model(input string tag);
        int i;
        i = int'(bus.addr % 32'd16384);
        if (i == KBD) check(tag, {23'b0, m_valid, m_data});
        else if (ref_mem.exists(i)) check(tag, ref_mem[i]);
    endtask

    task automatic drive(input logic r, input logic [31:0] a, input logic we,
                         input logic [31:0] wd, input logic s, input logic [7:0] k);
        rst_n = r; bus.addr = a; bus.MemWrite = we; bus.WD = wd;
        bus.sample = s; bus.key_reg = k;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 8'h00);
        tick(); tick();
        bus.addr = KBD; #1;
        check("reset_kbd", 32'h0);

        // Write 0xA5A5A5A5 to 0x1234 for five clocks.
        drive(1'b1, 32'h1234, 1'b1, 32'hA5A5A5A5, 1'b0, 8'd50);
        repeat (5) tick();
        drive(1'b1, 32'h1234, 1'b0, 32'hA5A5A5A5, 1'b0, 8'd50);
        check("wr_1234", 32'hA5A5A5A5);

        // No write with MemWrite low; then write 0x123C.
        drive(1'b1, 32'h123C, 1'b0, 32'hA5A5A596, 1'b0, 8'd50);
        tick();
        bus.MemWrite = 1'b1; #1;
        tick();
        bus.MemWrite = 1'b0; #1;
        check("wr_123c", 32'hA5A5A596);
        bus.addr = 32'h1234; #1;
        check("keep_1234", 32'hA5A5A5A5);

        // Read-during-write: old value before the edge, new after.
        drive(1'b1, 32'h0100, 1'b1, 32'h11112222, 1'b0, 8'd50);
        tick();
        drive(1'b1, 32'h0100, 1'b1, 32'h33334444, 1'b0, 8'd50);
        check("rdw_old", 32'h11112222);
        tick();
        check("rdw_new", 32'h33334444);

        // Keyboard capture.
        drive(1'b0, KBD, 1'b0, 32'h0, 1'b0, 8'd50);
        tick();
        drive(1'b1, KBD, 1'b0, 32'h0, 1'b0, 8'd50);
        tick();
        check("kbd_idle", 32'h0);
        drive(1'b1, KBD, 1'b0, 32'h0, 1'b1, 8'd51);
        check("kbd_pre_edge", 32'h0);
        tick();
        check("kbd_capture", 32'h133);
        drive(1'b1, KBD, 1'b0, 32'h0, 1'b1, 8'd52);
        tick(); tick();
        check("kbd_held", 32'h133);
        drive(1'b1, KBD, 1'b0, 32'h0, 1'b0, 8'd52);
        tick();
        check("kbd_fall", 32'h133);
        drive(1'b1, KBD, 1'b0, 32'h0, 1'b1, 8'd52);
        tick();
        check("kbd_recapture", 32'h134);

        // Writes to the keyboard word.
        drive(1'b1, KBD, 1'b1, 32'h0000_01FF, 1'b1, 8'd52);
        tick();
        check("kbd_wr_keep", 32'h134);
        drive(1'b1, KBD, 1'b1, 32'h0, 1'b1, 8'd52);
        tick();
        drive(1'b1, KBD, 1'b0, 32'h0, 1'b1, 8'd52);
        check("kbd_clear", 32'h034);
        bus.addr = 32'h5234; #1;
        check("alias_5234", 32'hA5A5A5A5);

        // Capture wins over same-cycle clear.
        drive(1'b1, KBD, 1'b0, 32'h0, 1'b0, 8'd52);
        tick();
        drive(1'b1, KBD, 1'b1, 32'h0, 1'b1, 8'h41);
        tick();
        drive(1'b1, KBD, 1'b0, 32'h0, 1'b1, 8'h41);
        check("capture_wins", 32'h141);

        // Reset priority: write and edge during reset are ignored.
        drive(1'b1, KBD, 1'b0, 32'h0, 1'b0, 8'h41);
        tick();
        drive(1'b0, 32'h1234, 1'b1, 32'hDEADBEEF, 1'b1, 8'h77);
        tick();
        check("rst_no_write", 32'hA5A5A5A5);
        bus.addr = KBD; #1;
        check("rst_kbd_zero", 32'h0);
        drive(1'b1, KBD, 1'b0, 32'h0, 1'b1, 8'h77);
        tick();
        check("post_rst_capture", 32'h177);

        // Randomized phase over a small address pool including the keyboard word.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'(i * 37), 1'b1, $urandom, 1'b1, 8'h00);
            tick();
        end
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a;
            int sel;
            sel = $urandom_range(0, 8);
            a = (sel == 8) ? 32'(KBD) : 32'(sel * 37);
            a[31:14] = 18'($urandom);
            drive(($urandom_range(0, 19) != 0), a, 1'($urandom), $urandom,
                  1'($urandom), 8'($urandom));
            check_model("rand_pre");
            tick();
            check_model("rand_post");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
